// File: rtl/phantom_clock_gate.sv
// -----------------------------------------------------------------------------
// phantom_clock_gate
//
// DS1215-style phantom timekeeper that sits on the card's shared RAM/ROM
// select path. While idle (MATCH) it watches single-bit writes on D0 inside
// the nRAMROMCS window. When they spell the 64-bit recognition pattern, it
// switches to CLOCK mode for the next 64 accesses. In CLOCK mode RAM/ROM is
// gated off, and the BCD time register is exchanged bit-serially on D0:
//   - 64 consecutive writes load a new time.
//   - any read in the 64 accesses discards the written bits, leaving TIME
//     unchanged.
//
// Optional feature (macro PHANTOM_TIMEKEEP_EN):
//   defined     - TICK (100 Hz) advances hundredths/seconds/minutes/hours in
//                 BCD. All carries resolve in the same cycle as TICK.
//   not defined - TICK is ignored. TIME changes only through a full load.
//
// Ports:
//   C7M        in  7 MHz clock. All state updates on the rising edge.
//   RES        in  synchronous active-high reset
//   nRAMROMCS  in  combined RAM/ROM select, active-low
//   ACC        in  one-cycle end-of-access strobe (qualified by nRAMROMCS low)
//   nWE        in  6502 R/W, 1 = read. Valid with ACC.
//   DIN        in  D0 of the write data. Valid with ACC.
//   TICK       in  one-cycle 100 Hz timebase pulse
//   RAMROMCSgb out gated select, active-high: ~nRAMROMCS & ~CLKMODE
//   DOUT       out serial read bit (SR[0]), registered
//   DOE        out drive D0 with DOUT: CLKMODE & ~nRAMROMCS & nWE
// -----------------------------------------------------------------------------
module phantom_clock_gate (
    input  logic C7M,
    input  logic RES,
    input  logic nRAMROMCS,
    input  logic ACC,
    input  logic nWE,
    input  logic DIN,
    input  logic TICK,
    output logic RAMROMCSgb,
    output logic DOUT,
    output logic DOE
);

    // Recognition pattern C5 3A A3 5C C5 3A A3 5C. Byte 0 occupies bits 7:0
    // and is sent first, LSB first, so bit index == access index.
    localparam logic [63:0] PATTERN = 64'h5CA3_3AC5_5CA3_3AC5;

    typedef enum logic {
        ST_MATCH = 1'b0,
        ST_CLOCK = 1'b1
    } state_t;

    state_t      state_reg, state_next;
    logic [5:0]  cnt_reg, cnt_next;
    logic [63:0] sr_reg, sr_next;
    logic [63:0] time_reg, time_next;
    logic        wrall_reg, wrall_next;

    // Internal handshake and datapath helpers
    logic        acc_valid;
    logic        clkmode;
    logic        pattern_bit;
    logic        last_access;
    logic        shift_in;
    logic [63:0] sr_shifted;
    logic        wrall_after;
    logic        load_time;
    logic [63:0] time_ticked;

    genvar gi;

    // Strobes outside the select window belong to other devices.
    assign acc_valid   = ACC & ~nRAMROMCS;
    assign clkmode     = (state_reg == ST_CLOCK);
    assign pattern_bit = PATTERN[cnt_reg];
    assign last_access = (cnt_reg == 6'd63);

    // Reads recirculate SR[0], so a pure read pass leaves SR rotated back
    // to the snapshot. Writes insert DIN at the top. After 64 writes, the
    // first bit written therefore lands in bit 0.
    assign shift_in    = nWE ? sr_reg[0] : DIN;
    assign sr_shifted  = {shift_in, sr_reg[63:1]};
    assign wrall_after = wrall_reg & ~nWE;

    // -------------------------------------------------------------------------
    // Time-of-day counter (next value when no load occurs)
    // -------------------------------------------------------------------------
`ifdef PHANTOM_TIMEKEEP_EN
    // carry[n] = "field n increments this cycle". The chain is purely
    // combinational, so 23:59:59.99 -> 00:00:00.00 resolves in one TICK.
    logic [3:0] carry;
    assign carry[0] = TICK;

    for (gi = 0; gi < 4; gi++) begin : g_count_field
        localparam logic [7:0] LIMIT = (gi == 0) ? 8'h99 :
                                       (gi == 3) ? 8'h23 : 8'h59;
        logic [7:0] field;
        logic [7:0] field_inc;
        logic       at_limit;

        assign field    = time_reg[8*gi +: 8];
        assign at_limit = (field == LIMIT);
        // BCD increment: a units digit of 9 carries into the tens digit.
        assign field_inc = (field[3:0] >= 4'd9) ?
                           {field[7:4] + 4'd1, 4'd0} :
                           {field[7:4], field[3:0] + 4'd1};

        assign time_ticked[8*gi +: 8] = !carry[gi] ? field :
                                        (at_limit ? 8'h00 : field_inc);

        // Hours wrap with no further carry, so the chain stops at field 3.
        if (gi < 3) begin : g_carry
            assign carry[gi+1] = carry[gi] & at_limit;
        end
    end

    // Day, date, month and year are held; only a load changes them.
    for (gi = 4; gi < 8; gi++) begin : g_hold_field
        assign time_ticked[8*gi +: 8] = time_reg[8*gi +: 8];
    end
`else
    logic unused_tick;
    assign unused_tick = TICK;

    for (gi = 0; gi < 8; gi++) begin : g_hold_field
        assign time_ticked[8*gi +: 8] = time_reg[8*gi +: 8];
    end
`endif

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        sr_next    = sr_reg;
        wrall_next = wrall_reg;
        load_time  = 1'b0;

        case (state_reg)
            ST_MATCH: begin
                if (acc_valid) begin
                    if (!nWE && (DIN == pattern_bit)) begin
                        if (last_access) begin
                            // The snapshot is taken from the pre-tick TIME.
                            // A coincident TICK still advances TIME itself.
                            state_next = ST_CLOCK;
                            cnt_next   = 6'd0;
                            sr_next    = time_reg;
                            wrall_next = 1'b1;
                        end else begin
                            cnt_next = cnt_reg + 6'd1;
                        end
                    end else begin
                        // Any read or wrong bit restarts recognition.
                        cnt_next = 6'd0;
                    end
                end
            end

            ST_CLOCK: begin
                if (acc_valid) begin
                    sr_next    = sr_shifted;
                    cnt_next   = cnt_reg + 6'd1;
                    wrall_next = wrall_after;
                    if (last_access) begin
                        state_next = ST_MATCH;
                        cnt_next   = 6'd0;
                        load_time  = wrall_after;
                    end
                end
            end

            default: begin
                state_next = ST_MATCH;
                cnt_next   = 6'd0;
            end
        endcase
    end

    // A load takes priority over a tick in the same cycle. That tick is lost.
    assign time_next = load_time ? sr_shifted : time_ticked;

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge C7M) begin
        if (RES) begin
            state_reg <= ST_MATCH;
            cnt_reg   <= 6'd0;
            sr_reg    <= 64'd0;
            wrall_reg <= 1'b0;
            time_reg  <= 64'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            sr_reg    <= sr_next;
            wrall_reg <= wrall_next;
            time_reg  <= time_next;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    // Gating uses registered CLKMODE. The 64th pattern write still reaches
    // RAM, and the 64th clock access is still gated.
    assign RAMROMCSgb = ~nRAMROMCS & ~clkmode;
    assign DOE        = clkmode & ~nRAMROMCS & nWE;
    assign DOUT       = sr_reg[0];

endmodule

// File: tb/tb_phantom_clock_gate.sv
module tb_phantom_clock_gate;

    logic C7M = 1'b0;
    logic RES, nRAMROMCS, ACC, nWE, DIN, TICK;
    logic RAMROMCSgb, DOUT, DOE;

    int checks = 0;
    int errors = 0;

    // Outputs captured mid-access, before the ACC edge
    logic s_gb, s_doe, s_dout;

    logic [7:0] pat_bytes [0:7] = '{8'hC5, 8'h3A, 8'hA3, 8'h5C,
                                    8'hC5, 8'h3A, 8'hA3, 8'h5C};

    typedef struct {
        logic [63:0] load;
        int          ticks;
        logic        tick_on_load;
        logic [63:0] expect_val;
    } vec_t;

    vec_t vecs [7];

    phantom_clock_gate dut (
        .C7M        (C7M),
        .RES        (RES),
        .nRAMROMCS  (nRAMROMCS),
        .ACC        (ACC),
        .nWE        (nWE),
        .DIN        (DIN),
        .TICK       (TICK),
        .RAMROMCSgb (RAMROMCSgb),
        .DOUT       (DOUT),
        .DOE        (DOE)
    );

    always #5 C7M = ~C7M;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end else
            $display("ok   %s: %0b", name, act);
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else
            $display("ok   %s: %0d", name, act);
    endtask

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %016h expected %016h", name, act, exp);
        end else
            $display("ok   %s: %016h", name, act);
    endtask

    // One 6502 access: select, sample outputs, then end with a one-cycle ACC.
    task automatic access(input logic rd, input logic d, input logic tick_on_acc);
        @(negedge C7M);
        nRAMROMCS = 1'b0; nWE = rd; DIN = d;
        @(negedge C7M);
        s_gb = RAMROMCSgb; s_doe = DOE; s_dout = DOUT;
        ACC = 1'b1; TICK = tick_on_acc;
        @(negedge C7M);
        ACC = 1'b0; TICK = 1'b0; nRAMROMCS = 1'b1; nWE = 1'b1; DIN = 1'b0;
    endtask

    // ACC pulse while not selected: a read here must not reset recognition.
    task automatic stray_acc();
        @(negedge C7M);
        nRAMROMCS = 1'b1; nWE = 1'b1; ACC = 1'b1;
        @(negedge C7M);
        ACC = 1'b0;
    endtask

    task automatic pulse_tick();
        @(negedge C7M); TICK = 1'b1;
        @(negedge C7M); TICK = 1'b0;
    endtask

    task automatic send_pattern(input int corrupt_bit, input int stray_at, output int bad);
        logic [7:0] b;
        logic bit_v;
        bad = 0;
        for (int i = 0; i < 64; i++) begin
            if (i == stray_at) stray_acc();
            b = pat_bytes[i / 8];
            bit_v = b[i % 8];
            if (i == corrupt_bit) bit_v = ~bit_v;
            access(1'b0, bit_v, 1'b0);
            if (s_gb !== 1'b1) bad++;
        end
    endtask

    task automatic read_time(output logic [63:0] t, output int bad);
        bad = 0;
        t = '0;
        for (int i = 0; i < 64; i++) begin
            access(1'b1, 1'b0, 1'b0);
            t[i] = s_dout;
            if (s_gb !== 1'b0 || s_doe !== 1'b1) bad++;
        end
    endtask

    task automatic write_time(input logic [63:0] v, input logic tick_last, output int bad);
        bad = 0;
        for (int i = 0; i < 64; i++) begin
            access(1'b0, v[i], tick_last && (i == 63));
            if (s_gb !== 1'b0 || s_doe !== 1'b0) bad++;
        end
    endtask

    task automatic readback(input string name, input logic [63:0] exp);
        int bad;
        logic [63:0] t;
        send_pattern(-1, -1, bad);
        check_int({name, "_pat_passthru"}, bad, 0);
        read_time(t, bad);
        check_int({name, "_rd_gated"}, bad, 0);
        check64({name, "_time"}, t, exp);
        access(1'b1, 1'b0, 1'b0);
        check1({name, "_65th_ungated"}, s_gb, 1'b1);
    endtask

    task automatic load(input string name, input logic [63:0] v, input logic tick_last);
        int bad;
        send_pattern(-1, -1, bad);
        write_time(v, tick_last, bad);
        check_int({name, "_wr_gated"}, bad, 0);
    endtask

    initial begin
        int bad;
        logic [63:0] t;
        logic [63:0] v_known;

        vecs[0] = '{64'h2412310523595999, 0, 1'b0, 64'h2412310523595999};
        vecs[1] = '{64'hFFEEDDCCBBAA9988, 0, 1'b0, 64'hFFEEDDCCBBAA9988};
        vecs[5] = '{64'h0000000000000099, 0, 1'b1, 64'h0000000000000099};
        vecs[6] = '{64'h0000000000000000, 0, 1'b0, 64'h0000000000000000};
`ifdef PHANTOM_TIMEKEEP_EN
        vecs[2] = '{64'h2412310523595999, 1, 1'b0, 64'h2412310500000000};
        vecs[3] = '{64'h1122334400001298, 3, 1'b0, 64'h1122334400001301};
        vecs[4] = '{64'h0000000009595999, 1, 1'b0, 64'h0000000010000000};
`else
        vecs[2] = '{64'h2412310523595999, 1, 1'b0, 64'h2412310523595999};
        vecs[3] = '{64'h1122334400001298, 3, 1'b0, 64'h1122334400001298};
        vecs[4] = '{64'h0000000009595999, 1, 1'b0, 64'h0000000009595999};
`endif

        RES = 1'b1; nRAMROMCS = 1'b1; ACC = 1'b0; nWE = 1'b1; DIN = 1'b0; TICK = 1'b0;
        repeat (3) @(posedge C7M);
        @(negedge C7M); RES = 1'b0;

        // Reset state
        #1 check1("reset_gb_idle", RAMROMCSgb, 1'b0);
        nRAMROMCS = 1'b0;
        #1 check1("reset_gb_sel", RAMROMCSgb, 1'b1);
        check1("reset_doe", DOE, 1'b0);
        check1("reset_dout", DOUT, 1'b0);
        nRAMROMCS = 1'b1;
        readback("reset", 64'h0);

        // Table: load, optional ticks, read back
        for (int k = 0; k < 7; k++) begin
            load($sformatf("vec%0d", k), vecs[k].load, vecs[k].tick_on_load);
            for (int n = 0; n < vecs[k].ticks; n++) pulse_tick();
            readback($sformatf("vec%0d", k), vecs[k].expect_val);
        end

        // Mismatch at bit 40: no clock mode, select passes through
        send_pattern(40, -1, bad);
        access(1'b1, 1'b0, 1'b0);
        check1("mismatch_gb", s_gb, 1'b1);
        check1("mismatch_doe", s_doe, 1'b0);

        // Discard: 63 writes + 1 read leaves TIME unchanged
        v_known = 64'h2412310523595999;
        load("discard_setup", v_known, 1'b0);
        send_pattern(-1, -1, bad);
        for (int i = 0; i < 63; i++) access(1'b0, ~v_known[i], 1'b0);
        access(1'b1, 1'b0, 1'b0);
        check1("discard_64th_gated", s_gb, 1'b0);
        access(1'b1, 1'b0, 1'b0);
        check1("discard_next_ungated", s_gb, 1'b1);
        readback("discard", v_known);

        // ACC while deselected is ignored during recognition
        send_pattern(-1, 32, bad);
        read_time(t, bad);
        check_int("stray_rd_gated", bad, 0);
        check64("stray_time", t, v_known);

        // Reset mid-sequence abandons the load and clears TIME
        send_pattern(-1, -1, bad);
        for (int i = 0; i < 10; i++) access(1'b0, 1'b1, 1'b0);
        @(negedge C7M); RES = 1'b1;
        @(negedge C7M); RES = 1'b0;
        access(1'b1, 1'b0, 1'b0);
        check1("reset_mid_gb", s_gb, 1'b1);
        readback("reset_mid", 64'h0);

        // Tick during CLOCK: snapshot unaffected, TIME still counts
        send_pattern(-1, -1, bad);
        t = '0;
        for (int i = 0; i < 64; i++) begin
            if (i == 10) pulse_tick();
            access(1'b1, 1'b0, 1'b0);
            t[i] = s_dout;
        end
        check64("tick_in_clock_snapshot", t, 64'h0);
`ifdef PHANTOM_TIMEKEEP_EN
        readback("tick_in_clock_after", 64'h1);
`else
        readback("tick_in_clock_after", 64'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
